// File: rtl/osd_event_pkg.sv
// rtl/osd_event_pkg.sv - shared constants, state type and header builder for the event packetizer
package osd_event_pkg;

   localparam int PKT_FLITS    = 5;
   localparam int HDR_DROP_BIT = 15;
   localparam int HDR_TYPE_MSB = 14;
   localparam int HDR_TYPE_LSB = 12;

   localparam logic [2:0] FLIT_TYPE_EVENT = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEST,
      S_SRC,
      S_HDR,
      S_TS_HI,
      S_TS_LO
   } pkt_state_t;

   // Header flit: drop marker on top, packet type below it, zero-extended event id at the bottom.
   function automatic logic [15:0] make_hdr(input logic drop, input logic [2:0] ptype,
                                            input logic [11:0] id);
      logic [15:0] h;
      h = '0;
      h[HDR_DROP_BIT] = drop;
      h[HDR_TYPE_MSB:HDR_TYPE_LSB] = ptype;
      h[HDR_TYPE_LSB-1:0] = id;
      return h;
   endfunction

endpackage

// File: rtl/event_packetizer_if.sv
// rtl/event_packetizer_if.sv - 16-bit flit stream towards the debug NoC
interface event_packetizer_if;

   logic [15:0] out_flit;
   logic        out_valid;
   logic        out_last;
   logic        out_ready;

   modport master (output out_flit, output out_valid, output out_last, input out_ready);
   modport slave  (input out_flit, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous event FIFO with head and next-head lookahead
module event_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [WIDTH-1:0]         next_head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;

   // Entry storage; written only when the caller has accepted the push.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; level is the registered count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   assign rd_next = rd_ptr + 1'b1;
   assign head    = mem[rd_ptr];
   // With a single entry left, the next head after a pop is whatever is being pushed right now.
   assign next_head = (level > LW'(1)) ? mem[rd_next] : push_data;
   assign empty     = (level == '0);
   assign full      = (level == LW'(DEPTH));

endmodule

// File: rtl/event_packetizer.sv
// rtl/event_packetizer.sv - buffers event strobes and serialises each into a 5-flit debug packet
module event_packetizer
   import osd_event_pkg::*;
#(
   parameter int          EVENT_ID_WIDTH  = 5,
   parameter int          TIMESTAMP_WIDTH = 32,
   parameter int          FIFO_DEPTH      = 8,
   parameter logic [15:0] DEST            = 16'h0000,
   parameter logic [15:0] SRC             = 16'h0000,
   parameter logic [2:0]  TYPE            = FLIT_TYPE_EVENT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            diag_sys_enabled,
   input  logic                            ev_valid,
   input  logic [EVENT_ID_WIDTH-1:0]       ev_id,
   input  logic [TIMESTAMP_WIDTH-1:0]      ev_time,
   event_packetizer_if.master              noc,
   output logic [7:0]                      overflow_cnt,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int EW = EVENT_ID_WIDTH + TIMESTAMP_WIDTH + 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   pkt_state_t                  state;
   logic [EW-1:0]               head;
   logic [EW-1:0]               next_head;
   logic [EW-1:0]               hold;
   logic                        hold_drop;
   logic [EVENT_ID_WIDTH-1:0]   hold_id;
   logic [TIMESTAMP_WIDTH-1:0]  hold_time;
   logic                        fifo_empty;
   logic                        fifo_full;
   logic                        drop_flag;
   logic                        push_req;
   logic                        push_ok;
   logic                        pop;
   logic                        accept;

   assign push_req = ev_valid && diag_sys_enabled;
   assign accept   = noc.out_valid && noc.out_ready;
   assign pop      = accept && (state == S_TS_LO);
   // A full FIFO still takes the event when the head leaves in the same cycle.
   assign push_ok  = push_req && (!fifo_full || pop);
   assign {hold_drop, hold_id, hold_time} = hold;

   event_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_ok),
      .push_data ({drop_flag, ev_id, ev_time}),
      .pop       (pop),
      .head      (head),
      .next_head (next_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .level     (fifo_level)
   );

   // Loss accounting: saturating drop counter and a sticky flag carried by the next stored event.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_cnt <= '0;
         drop_flag    <= 1'b0;
      end else if (push_ok) begin
         drop_flag <= 1'b0;
      end else if (push_req) begin
         drop_flag <= 1'b1;
         if (overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

   // Packet serialiser; outputs are registered and only move on an accepted flit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         hold          <= '0;
         noc.out_flit  <= '0;
         noc.out_valid <= 1'b0;
         noc.out_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  hold          <= head;
                  state         <= S_DEST;
                  noc.out_flit  <= DEST;
                  noc.out_valid <= 1'b1;
               end
            end
            S_DEST: begin
               if (accept) begin
                  state        <= S_SRC;
                  noc.out_flit <= SRC;
               end
            end
            S_SRC: begin
               if (accept) begin
                  state        <= S_HDR;
                  noc.out_flit <= make_hdr(hold_drop, TYPE, 12'(hold_id));
               end
            end
            S_HDR: begin
               if (accept) begin
                  state        <= S_TS_HI;
                  noc.out_flit <= hold_time[31:16];
               end
            end
            S_TS_HI: begin
               if (accept) begin
                  state        <= S_TS_LO;
                  noc.out_flit <= hold_time[15:0];
                  noc.out_last <= 1'b1;
               end
            end
            S_TS_LO: begin
               if (accept) begin
                  noc.out_last <= 1'b0;
                  if ((fifo_level > LW'(1)) || push_ok) begin
                     hold         <= next_head;
                     state        <= S_DEST;
                     noc.out_flit <= DEST;
                  end else begin
                     state         <= S_IDLE;
                     noc.out_flit  <= '0;
                     noc.out_valid <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_event_packetizer.sv
// tb/tb_event_packetizer.sv - self-checking bench for event_packetizer
module tb_event_packetizer;
   import osd_event_pkg::*;

   localparam logic [15:0] DEST_P = 16'hD001;
   localparam logic [15:0] SRC_P  = 16'h5002;
   localparam logic [2:0]  TYPE_P = 3'b010;
   localparam int          DEPTH  = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        ev_valid = 1'b0;
   logic [4:0]  ev_id = '0;
   logic [31:0] ev_time = '0;
   logic [7:0]  overflow_cnt;
   logic [3:0]  fifo_level;

   int n_checks = 0;
   int n_fail   = 0;

   event_packetizer_if noc ();

   event_packetizer #(
      .EVENT_ID_WIDTH  (5),
      .TIMESTAMP_WIDTH (32),
      .FIFO_DEPTH      (DEPTH),
      .DEST            (DEST_P),
      .SRC             (SRC_P),
      .TYPE            (TYPE_P)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .diag_sys_enabled (en),
      .ev_valid         (ev_valid),
      .ev_id            (ev_id),
      .ev_time          (ev_time),
      .noc              (noc.master),
      .overflow_cnt     (overflow_cnt),
      .fifo_level       (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of stored events, expected flit stream, drop flag and loss count.
   logic        mon_on = 1'b0;
   logic [37:0] mq[$];
   logic [16:0] exp_flits[$];
   logic [15:0] acc_log[$];
   logic        m_drop = 1'b0;
   int          m_ovf = 0;
   logic        prev_stall = 1'b0;
   logic [16:0] prev_out = '0;

   always @(negedge clk) begin
      logic        acc;
      logic        pop_now;
      logic [16:0] f;
      int          pending;
      int          sz;
      if (mon_on) begin
         acc     = noc.out_valid && noc.out_ready;
         pending = exp_flits.size();
         if (pending == 0) chk("idle_valid", {31'b0, noc.out_valid}, 32'd0);
         if (prev_stall)
            chk("stall_hold", {14'b0, noc.out_valid, noc.out_last, noc.out_flit}, {14'b0, 1'b1, prev_out});
         if (acc) begin
            acc_log.push_back(noc.out_flit);
            if (pending == 0) begin
               chk("unexpected_flit", {15'b0, noc.out_last, noc.out_flit}, 32'hFFFF_FFFF);
            end else begin
               f = exp_flits.pop_front();
               chk("flit", {15'b0, noc.out_last, noc.out_flit}, {15'b0, f});
            end
         end
         chk("level", {28'b0, fifo_level}, mq.size());
         chk("overflow_cnt", {24'b0, overflow_cnt}, m_ovf);
         prev_stall = noc.out_valid && !noc.out_ready && !rst;
         prev_out   = {noc.out_last, noc.out_flit};
         if (rst) begin
            mq.delete();
            exp_flits.delete();
            m_drop = 1'b0;
            m_ovf  = 0;
         end else begin
            pop_now = acc && noc.out_last;
            sz = mq.size();
            if (pop_now && sz > 0) void'(mq.pop_front());
            if (ev_valid && en) begin
               if (sz < DEPTH || pop_now) begin
                  mq.push_back({m_drop, ev_id, ev_time});
                  exp_flits.push_back({1'b0, DEST_P});
                  exp_flits.push_back({1'b0, SRC_P});
                  exp_flits.push_back({1'b0, m_drop, TYPE_P, 7'b0, ev_id});
                  exp_flits.push_back({1'b0, ev_time[31:16]});
                  exp_flits.push_back({1'b1, ev_time[15:0]});
                  m_drop = 1'b0;
               end else begin
                  m_drop = 1'b1;
                  if (m_ovf < 255) m_ovf++;
               end
            end
         end
      end
   end

   typedef struct {
      logic        ev;
      logic        rdy;
      logic        v;
      logic [15:0] flit;
      logic        last;
      logic [3:0]  lvl;
   } vec_t;

   vec_t tbl[21];

   function automatic vec_t mk(input logic ev, input logic rdy, input logic v,
                               input logic [15:0] flit, input logic last, input logic [3:0] lvl);
      vec_t r;
      r.ev = ev; r.rdy = rdy; r.v = v; r.flit = flit; r.last = last; r.lvl = lvl;
      return r;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int w;
      // single event id=5 t=DEADBEEF with out_ready=1
      tbl[0]  = mk(1, 1, 0, 16'h0000, 0, 0);
      tbl[1]  = mk(0, 1, 0, 16'h0000, 0, 1);
      tbl[2]  = mk(0, 1, 1, DEST_P,   0, 1);
      tbl[3]  = mk(0, 1, 1, SRC_P,    0, 1);
      tbl[4]  = mk(0, 1, 1, 16'h2005, 0, 1);
      tbl[5]  = mk(0, 1, 1, 16'hDEAD, 0, 1);
      tbl[6]  = mk(0, 1, 1, 16'hBEEF, 1, 1);
      tbl[7]  = mk(0, 1, 0, 16'h0000, 0, 0);
      // same event with out_ready toggling 0/1
      tbl[8]  = mk(1, 0, 0, 16'h0000, 0, 0);
      tbl[9]  = mk(0, 1, 0, 16'h0000, 0, 1);
      tbl[10] = mk(0, 0, 1, DEST_P,   0, 1);
      tbl[11] = mk(0, 1, 1, DEST_P,   0, 1);
      tbl[12] = mk(0, 0, 1, SRC_P,    0, 1);
      tbl[13] = mk(0, 1, 1, SRC_P,    0, 1);
      tbl[14] = mk(0, 0, 1, 16'h2005, 0, 1);
      tbl[15] = mk(0, 1, 1, 16'h2005, 0, 1);
      tbl[16] = mk(0, 0, 1, 16'hDEAD, 0, 1);
      tbl[17] = mk(0, 1, 1, 16'hDEAD, 0, 1);
      tbl[18] = mk(0, 0, 1, 16'hBEEF, 1, 1);
      tbl[19] = mk(0, 1, 1, 16'hBEEF, 1, 1);
      tbl[20] = mk(0, 0, 0, 16'h0000, 0, 0);

      noc.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      chk("rst_valid", {31'b0, noc.out_valid}, 32'd0);
      chk("rst_last", {31'b0, noc.out_last}, 32'd0);
      chk("rst_flit", {16'b0, noc.out_flit}, 32'd0);
      chk("rst_level", {28'b0, fifo_level}, 32'd0);
      chk("rst_ovf", {24'b0, overflow_cnt}, 32'd0);
      rst = 1'b0;
      mon_on = 1'b1;

      for (int i = 0; i < 21; i++) begin
         chk($sformatf("tbl%0d_valid", i), {31'b0, noc.out_valid}, {31'b0, tbl[i].v});
         chk($sformatf("tbl%0d_last", i), {31'b0, noc.out_last}, {31'b0, tbl[i].last});
         chk($sformatf("tbl%0d_level", i), {28'b0, fifo_level}, {28'b0, tbl[i].lvl});
         if (tbl[i].v) chk($sformatf("tbl%0d_flit", i), {16'b0, noc.out_flit}, {16'b0, tbl[i].flit});
         ev_valid = tbl[i].ev;
         ev_id = 5'd5;
         ev_time = 32'hDEADBEEF;
         noc.out_ready = tbl[i].rdy;
         step();
      end
      ev_valid = 1'b0;

      // back-to-back: three events, 15 contiguous flits
      noc.out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("b2b_valid_c%0d", c), {31'b0, noc.out_valid},
             (c >= 2 && c <= 1 + 3 * PKT_FLITS) ? 32'd1 : 32'd0);
         chk($sformatf("b2b_last_c%0d", c), {31'b0, noc.out_last},
             (c == 6 || c == 11 || c == 16) ? 32'd1 : 32'd0);
         ev_valid = (c < 3);
         ev_id = 5'(c + 1);
         ev_time = $urandom;
         step();
      end
      ev_valid = 1'b0;

      // overflow: ten events into a stalled FIFO of eight
      noc.out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         ev_valid = 1'b1;
         ev_id = 5'(k + 1);
         ev_time = {16'(16'h1000 + k), 16'(16'h2000 + k)};
         step();
      end
      ev_valid = 1'b0;
      step();
      step();
      chk("ovf_level", {28'b0, fifo_level}, 32'd8);
      chk("ovf_count", {24'b0, overflow_cnt}, 32'd2);
      acc_log.delete();
      noc.out_ready = 1'b1;
      w = 0;
      while (exp_flits.size() != 0 && w < 100) begin step(); w++; end
      step();
      chk("ovf_drained", exp_flits.size(), 32'd0);
      chk("ovf_flits", acc_log.size(), 32'd40);
      for (int k = 0; k < 8; k++)
         chk($sformatf("ovf_hdr%0d", k), {16'b0, acc_log[5 * k + 2]},
             {16'b0, 1'b0, TYPE_P, 7'b0, 5'(k + 1)});
      acc_log.delete();
      ev_valid = 1'b1;
      ev_id = 5'd11;
      ev_time = 32'hCAFE0011;
      step();
      ev_valid = 1'b0;
      w = 0;
      while (exp_flits.size() != 0 && w < 30) begin step(); w++; end
      step();
      chk("drop_pkt_flits", acc_log.size(), 32'd5);
      chk("drop_hdr", {16'b0, acc_log[2]}, 32'h0000A00B);

      // full FIFO with a push landing on the TS_LO acceptance
      noc.out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         ev_valid = 1'b1;
         ev_id = 5'(16 + k);
         ev_time = $urandom;
         step();
      end
      ev_valid = 1'b0;
      step();
      chk("fullpop_level_before", {28'b0, fifo_level}, 32'd8);
      noc.out_ready = 1'b1;
      w = 0;
      while (!(noc.out_valid && noc.out_last) && w < 20) begin step(); w++; end
      chk("fullpop_found_last", {31'b0, noc.out_valid && noc.out_last}, 32'd1);
      ev_valid = 1'b1;
      ev_id = 5'd24;
      ev_time = 32'h2424_0024;
      step();
      ev_valid = 1'b0;
      chk("fullpop_level", {28'b0, fifo_level}, 32'd8);
      chk("fullpop_ovf", {24'b0, overflow_cnt}, 32'd2);
      w = 0;
      while (exp_flits.size() != 0 && w < 100) begin step(); w++; end
      step();
      chk("fullpop_drained", exp_flits.size(), 32'd0);

      // enable low blocks capture; reset mid-packet abandons it
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ev_valid = 1'b1;
         ev_id = 5'(k);
         step();
      end
      ev_valid = 1'b0;
      repeat (3) step();
      chk("dis_level", {28'b0, fifo_level}, 32'd0);
      chk("dis_valid", {31'b0, noc.out_valid}, 32'd0);
      en = 1'b1;
      ev_valid = 1'b1;
      ev_id = 5'd7;
      ev_time = 32'h12345678;
      step();
      ev_valid = 1'b0;
      w = 0;
      while (!noc.out_valid && w < 10) begin step(); w++; end
      chk("rstmid_start", {31'b0, noc.out_valid}, 32'd1);
      repeat (3) step();
      chk("rstmid_ts_hi", {16'b0, noc.out_flit}, 32'h00001234);
      rst = 1'b1;
      step();
      chk("rstmid_valid", {31'b0, noc.out_valid}, 32'd0);
      chk("rstmid_level", {28'b0, fifo_level}, 32'd0);
      chk("rstmid_ovf", {24'b0, overflow_cnt}, 32'd0);
      rst = 1'b0;
      step();

      // randomized traffic against the model
      for (int c = 0; c < 2000; c++) begin
         en = ($urandom_range(0, 9) != 0);
         ev_valid = ($urandom_range(0, 9) < 3);
         ev_id = 5'($urandom);
         ev_time = $urandom;
         noc.out_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      ev_valid = 1'b0;
      noc.out_ready = 1'b1;
      w = 0;
      while (exp_flits.size() != 0 && w < 200) begin step(); w++; end
      step();
      chk("rand_drained", exp_flits.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
